// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constant control words for the pipeline hazard controller.
// Control word bit order: {pc_we, ifid/idex/exmem/memwb _we, ifid/idex/exmem/memwb _flush}.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    MDU_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = 9'b1_1111_0000;
  localparam ctrl_t CTRL_HOLD_ALL = 9'b0_0000_0000;
  localparam ctrl_t CTRL_INIT     = 9'b0_1111_1111;

endpackage

// File: rtl/pipe_perf_counter.sv
// Free-running 32-bit event counter with enable; wraps modulo 2^32.
module pipe_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        mdu_done,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t          state;
  state_t          state_nxt;
  ctrl_t           ctrl;
  logic            started;
  logic [TO_W-1:0] to_cnt;
  logic            to_fired;
  logic            mem_stall;
  logic            mdu_stall;
  logic            load_use;

  function automatic ctrl_t mem_wait_ctrl();
    ctrl_t c;
    c             = CTRL_HOLD_ALL;
    c.memwb_we    = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t mdu_wait_ctrl();
    ctrl_t c;
    c             = CTRL_HOLD_ALL;
    c.exmem_we    = 1'b1;
    c.exmem_flush = 1'b1;
    c.memwb_we    = 1'b1;
    return c;
  endfunction

  // Lower-priority RUN rules: MDU start, redirect, load-use, normal flow.
  function automatic ctrl_t run_rules(input logic mdu, input logic redir, input logic lu);
    ctrl_t c;
    c = CTRL_RUN;
    if (mdu) begin
      c = mdu_wait_ctrl();
    end else if (redir) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (lu) begin
      c.pc_we      = 1'b0;
      c.ifid_we    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

  assign mem_stall = mem_req & ~dmem_ready;
  assign mdu_stall = ex_mdu_start & ~mdu_done;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    ctrl      = CTRL_HOLD_ALL;
    state_nxt = state;
    case (state)
      INIT: begin
        // Stay silent until the first clock edge after reset release.
        if (started) begin
          ctrl      = CTRL_INIT;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (mem_stall) begin
          ctrl      = mem_wait_ctrl();
          state_nxt = MEM_WAIT;
        end else begin
          ctrl      = run_rules(mdu_stall, ex_redirect, load_use);
          state_nxt = mdu_stall ? MDU_WAIT : RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl = mem_wait_ctrl();
        end else begin
          ctrl      = run_rules(mdu_stall, ex_redirect, load_use);
          state_nxt = mdu_stall ? MDU_WAIT : RUN;
        end
      end
      MDU_WAIT: begin
        if (mem_stall) begin
          ctrl = mem_wait_ctrl();
        end else if (mdu_done) begin
          ctrl      = CTRL_RUN;
          state_nxt = RUN;
        end else begin
          ctrl = mdu_wait_ctrl();
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  assign mem_timeout = (state == MEM_WAIT) && (to_cnt == TO_LIMIT) && !to_fired;

  // Wait counter restarts on every MEM_WAIT entry and saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt   <= '0;
      to_fired <= 1'b0;
    end else if ((state_nxt == MEM_WAIT) && (state != MEM_WAIT)) begin
      to_cnt   <= '0;
      to_fired <= 1'b0;
    end else if (state == MEM_WAIT) begin
      if (to_cnt != TO_LIMIT) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (mem_timeout) begin
        to_fired <= 1'b1;
      end
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign idex_we     = ctrl.idex_we;
  assign exmem_we    = ctrl.exmem_we;
  assign memwb_we    = ctrl.memwb_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;

`ifdef PIPE_PERF_EN
  logic counted;
  logic any_flush;

  assign counted   = (state != INIT);
  assign any_flush = ctrl.ifid_flush | ctrl.idex_flush | ctrl.exmem_flush | ctrl.memwb_flush;

  pipe_perf_counter u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (counted & ~ctrl.pc_we),
    .count (stall_cycles)
  );

  pipe_perf_counter u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (counted & any_flush),
    .count (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT reduced to 4).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, ifid, idex, exmem, memwb we ; ifid, idex, exmem, memwb flush}
  localparam logic [8:0] E_ZERO  = 9'b0_0000_0000;
  localparam logic [8:0] E_INIT  = 9'b0_1111_1111;
  localparam logic [8:0] E_RUN   = 9'b1_1111_0000;
  localparam logic [8:0] E_MEM   = 9'b0_0001_0001;
  localparam logic [8:0] E_MDU   = 9'b0_0011_0010;
  localparam logic [8:0] E_REDIR = 9'b1_1111_1100;
  localparam logic [8:0] E_LU    = 9'b0_0111_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        ex_mdu_start, mdu_done, mem_req, dmem_ready;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic [8:0]  ctrl_obs;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  assign ctrl_obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush};

  pipe_hazard_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .ex_mdu_start (ex_mdu_start),
    .mdu_done     (mdu_done),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .memwb_we     (memwb_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    ex_mdu_start = 1'b0; mdu_done = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Inputs for the cycle are already applied; sample 1 time unit later,
  // then fold this cycle's expected contribution into the counter model.
  task automatic check_cycle(input string tag, input logic [8:0] exp_ctrl,
                             input logic exp_to, input bit counted);
    #1;
    chk({tag, "/ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl));
    chk({tag, "/timeout"}, 32'(mem_timeout), 32'(exp_to));
    chk({tag, "/stall_cycles"}, stall_cycles, PERF ? 32'(exp_stall) : 32'd0);
    chk({tag, "/flush_events"}, flush_events, PERF ? 32'(exp_flush) : 32'd0);
    if (counted) begin
      if (!exp_ctrl[8]) exp_stall++;
      if (|exp_ctrl[3:0]) exp_flush++;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;

    // Reset and start-up
    @(negedge clk); check_cycle("reset", E_ZERO, 1'b0, 0);
    @(negedge clk); rst = 1'b0; check_cycle("pre_edge", E_ZERO, 1'b0, 0);
    @(negedge clk); check_cycle("init", E_INIT, 1'b0, 0);
    @(negedge clk); check_cycle("run0", E_RUN, 1'b0, 1);
    @(negedge clk); check_cycle("run1", E_RUN, 1'b0, 1);

    // Load-use on rs2, then the same hazard against x0
    @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    check_cycle("lu_rs2", E_LU, 1'b0, 1);
    @(negedge clk); ex_mem_read = 1'b0;
    check_cycle("lu_release", E_RUN, 1'b0, 1);
    @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    check_cycle("lu_x0", E_RUN, 1'b0, 1);

    // Redirect beats a simultaneous load-use
    @(negedge clk); ex_rd = 5'd5; id_rs2 = 5'd5; ex_redirect = 1'b1;
    check_cycle("redir_vs_lu", E_REDIR, 1'b0, 1);
    @(negedge clk); idle();
    check_cycle("post_redir", E_RUN, 1'b0, 1);

    // Load-use on rs1, and the same registers when rs1 is not read
    @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    check_cycle("lu_rs1", E_LU, 1'b0, 1);
    @(negedge clk); id_use_rs1 = 1'b0;
    check_cycle("lu_rs1_unused", E_RUN, 1'b0, 1);
    @(negedge clk); idle();

    // Data memory wait of 3 cycles, released on the 4th
    mem_req = 1'b1; dmem_ready = 1'b0;
    check_cycle("mem_w1", E_MEM, 1'b0, 1);
    @(negedge clk); check_cycle("mem_w2", E_MEM, 1'b0, 1);
    @(negedge clk); check_cycle("mem_w3", E_MEM, 1'b0, 1);
    @(negedge clk); dmem_ready = 1'b1;
    check_cycle("mem_release", E_RUN, 1'b0, 1);
    @(negedge clk); idle();
    check_cycle("mem_after", E_RUN, 1'b0, 1);

    // MDU with done 4 cycles after start; memory wait injected on cycle 2
    @(negedge clk); ex_mdu_start = 1'b1;
    check_cycle("mdu_start", E_MDU, 1'b0, 1);
    @(negedge clk); ex_mdu_start = 1'b0;
    check_cycle("mdu_w1", E_MDU, 1'b0, 1);
    @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0;
    check_cycle("mdu_mem_prio", E_MEM, 1'b0, 1);
    @(negedge clk); mem_req = 1'b0; dmem_ready = 1'b1;
    check_cycle("mdu_w3", E_MDU, 1'b0, 1);
    @(negedge clk); mdu_done = 1'b1;
    check_cycle("mdu_done", E_RUN, 1'b0, 1);
    @(negedge clk); mdu_done = 1'b0;
    check_cycle("mdu_after", E_RUN, 1'b0, 1);

    // Timeout: ready low for 10 cycles, pulse on the 5th MEM_WAIT cycle only
    @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0;
    check_cycle("to_entry", E_MEM, 1'b0, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_cycle($sformatf("to_wait%0d", k), E_MEM, (k == 5), 1);
    end
    @(negedge clk); dmem_ready = 1'b1;
    check_cycle("to_release", E_RUN, 1'b0, 1);
    @(negedge clk); idle();
    check_cycle("to_after", E_RUN, 1'b0, 1);

    // Reset in the middle of a wait: outputs drop at once, no late pulse
    @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0;
    check_cycle("rw_entry", E_MEM, 1'b0, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_cycle($sformatf("rw_wait%0d", k), E_MEM, 1'b0, 1);
    end
    @(negedge clk); rst = 1'b1; exp_stall = 0; exp_flush = 0;
    check_cycle("rw_reset0", E_ZERO, 1'b0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_cycle($sformatf("rw_reset%0d", k), E_ZERO, 1'b0, 0);
    end
    @(negedge clk); rst = 1'b0; idle();
    check_cycle("rw_pre_edge", E_ZERO, 1'b0, 0);
    @(negedge clk); check_cycle("rw_init", E_INIT, 1'b0, 0);
    @(negedge clk); check_cycle("rw_run", E_RUN, 1'b0, 1);
    @(negedge clk); check_cycle("rw_run2", E_RUN, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit that drives the write-enable and flush inputs of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It is the producer side of the pipeline-register control interface. It detects load-use hazards, branch/jump redirects, multi-cycle mul/div occupancy and data-memory wait states. It sequences stalls, bubbles and flushes with a small state machine.

## Interface
- TIMEOUT, 255: maximum cycles in MEM_WAIT before `mem_timeout` pulses
- TO_W, 8: width of the wait-timeout counter; TIMEOUT < 2^TO_W
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  source register actually read
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  taken branch or jump resolved in EX
- ex_mdu_start  in  1  multi-cycle mul/div enters EX this cycle
- mdu_done  in  1  mul/div result valid this cycle
- mem_req  in  1  MEM stage issues a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC update enable
- ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipeline register write enable
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  pipeline register flush
- mem_timeout  out  1  one-cycle error pulse
- stall_cycles, flush_events  out  32 each  perf counters (see Configuration)

## Operation
- Register contract: a flush takes effect only when the matching `*_we`=1. A bubble is therefore `we=1, flush=1`. A hold is `we=0`, with flush don't-care and driven 0.
- States: INIT, RUN, MEM_WAIT, MDU_WAIT. The state is registered. All control outputs are combinational from the state and the current inputs.
- INIT (one cycle after reset): all four `*_we`=1, all four `*_flush`=1, `pc_we`=0. Next state is RUN.
- RUN conditions are evaluated in priority order; the first match applies.
- (1) MEM wait, `mem_req & ~dmem_ready`:
  - pc/ifid/idex/exmem hold.
  - MEM/WB bubble.
  - Next state is MEM_WAIT.
- (2) MDU start, `ex_mdu_start & ~mdu_done`:
  - pc/ifid/idex hold.
  - EX/MEM bubble.
  - MEM/WB writes normally.
  - Next state is MDU_WAIT.
- (3) Redirect, `ex_redirect`:
  - `pc_we`=1.
  - IF/ID and ID/EX bubble.
  - EX/MEM and MEM/WB write normally.
- (4) Load-use, `ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`:
  - pc/ifid hold.
  - ID/EX bubble.
  - Others write normally.
- (5) Otherwise all `we`=1 and all `flush`=0.
- MEM_WAIT: outputs are as in (1) while `~dmem_ready`. When `dmem_ready`=1, RUN rules (2)-(5) apply this cycle and the next state is RUN.
- MDU_WAIT: outputs are as in (2) while `~mdu_done`. When `mdu_done`=1, all `we`=1 and the next state is RUN.
- Memory has priority in MDU_WAIT. If `mem_req & ~dmem_ready` occurs in MDU_WAIT, the rule (1) outputs apply and the state stays MDU_WAIT.
- Timeout:
  - The counter clears on MEM_WAIT entry and increments each MEM_WAIT cycle.
  - When it reaches TIMEOUT, `mem_timeout`=1 for exactly one cycle.
  - The counter saturates and does not pulse again until re-entry.
- x0 never causes a load-use stall.

## Timing
- While rst=1: state=INIT, all `*_we`=0, all `*_flush`=0, `pc_we`=0, `mem_timeout`=0, counters 0.
- First rising edge after rst deasserts: INIT outputs are active. Second edge: RUN.
- Zero-cycle latency from hazard inputs to control outputs.
- Load-use costs exactly 1 bubble. Redirect costs exactly 2 flushed slots.
- MDU costs N+1 cycles in EX for `mdu_done` N cycles after start.
- rst asserted mid-MEM_WAIT or mid-MDU_WAIT aborts immediately to INIT. No timeout pulse is emitted.

## Configuration
- `PIPE_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_we`=0, excluding INIT.
  - `flush_events` increments once per cycle in which any `*_flush`=1, excluding INIT.
  - Both wrap modulo 2^32 and reset to 0.
- `PIPE_PERF_EN` undefined: both outputs are constant 0 and no counter flops exist.

## Structure
- Package `pipe_ctrl_pkg`: state enum (INIT, RUN, MEM_WAIT, MDU_WAIT) and a `ctrl_t` struct bundling the nine control outputs. It also holds constants `CTRL_RUN`, `CTRL_HOLD_ALL` and `CTRL_INIT`.
- Sub-module `pipe_perf_counter`: 32-bit enable counter with async reset. It is instantiated twice under `PIPE_PERF_EN`.

## Test plan
- Reset then idle inputs:
  - During rst, all outputs are 0.
  - Cycle 1: all we=1, all flush=1, pc_we=0.
  - Cycle 2 onward: all we=1, flush=0.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → pc_we=0, ifid_we=0, idex_we=1, idex_flush=1 for 1 cycle. Same stimulus with `ex_rd`=0 → no stall.
- `ex_redirect` and a load-use hazard in the same cycle → redirect wins: pc_we=1, ifid_flush=idex_flush=1, no hold.
- `mem_req`=1 with `dmem_ready` low for 3 cycles:
  - pc/ifid/idex/exmem held and memwb bubbled for 3 cycles.
  - Release on the 4th cycle.
  - `stall_cycles`=3 with `PIPE_PERF_EN`.
- `ex_mdu_start`, `mdu_done` 4 cycles later, `mem_req & ~dmem_ready` injected on cycle 2 → memwb bubble and exmem hold on cycle 2. State stays MDU_WAIT, then returns to RUN after `mdu_done`.
- TIMEOUT=4 with `dmem_ready` held low for 10 cycles → a single `mem_timeout` pulse on the 5th MEM_WAIT cycle. rst asserted mid-wait returns to INIT with no pulse.
